// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller and the front-end pipeline registers.
// The pipeline side drives the decode/execute fields; the controller drives the enables.
interface pipeline_hazard_ctrl_if #(
   parameter int RAW   = 5,
   parameter int CNT_W = 16
);
   logic [RAW-1:0]   id_rs;
   logic [RAW-1:0]   id_rt;
   logic             id_uses_rt;
   logic             id_is_md;
   logic             ex_memread;
   logic [RAW-1:0]   ex_rt;
   logic             ex_branch_taken;
   logic             pc_we;
   logic             ifid_we;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             md_start;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_is_md, ex_memread, ex_rt, ex_branch_taken,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_is_md, ex_memread, ex_rt, ex_branch_taken,
      output pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller: load-use stalls, taken-branch flushes and mul/div holds
// for the PC, IF/ID and ID/EX registers of the 5-stage pipeline.
module pipeline_hazard_ctrl #(
   parameter int RAW    = 5,
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int MW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

   typedef enum logic {
      RUN,
      MD_WAIT
   } state_t;

   state_t           state, state_next;
   logic [MW-1:0]    md_cnt, md_cnt_next;
   logic             md_done, md_done_next;
   logic [CNT_W-1:0] stall_cnt;
   logic             lu_haz;

   assign lu_haz = hz.ex_memread && (hz.ex_rt != '0) &&
                   ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

   assign hz.stall_cnt = stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         md_cnt    <= '0;
         md_done   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state   <= state_next;
         md_cnt  <= md_cnt_next;
         md_done <= md_done_next;
         if (!hz.pc_we && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // md_done masks id_is_md for the one cycle after a wait so the held op issues once
   always_comb begin
      state_next     = state;
      md_cnt_next    = md_cnt;
      md_done_next   = 1'b0;
      hz.pc_we       = 1'b1;
      hz.ifid_we     = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b0;
      hz.md_start    = 1'b0;
      hz.md_busy     = 1'b0;

      if (rst) begin
         hz.pc_we       = 1'b0;
         hz.ifid_we     = 1'b0;
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (hz.ex_branch_taken) begin
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
         state_next     = RUN;
         if (state == MD_WAIT)
            md_cnt_next = '0;
      end else begin
         case (state)
            RUN: begin
               if (lu_haz) begin
                  hz.pc_we       = 1'b0;
                  hz.ifid_we     = 1'b0;
                  hz.idex_bubble = 1'b1;
               end else if (hz.id_is_md && !md_done) begin
                  hz.md_start    = 1'b1;
                  hz.pc_we       = 1'b0;
                  hz.ifid_we     = 1'b0;
                  hz.idex_bubble = 1'b1;
                  state_next     = MD_WAIT;
                  md_cnt_next    = MW'(MD_LAT - 2);
               end
            end
            MD_WAIT: begin
               hz.md_busy     = 1'b1;
               hz.pc_we       = 1'b0;
               hz.ifid_we     = 1'b0;
               hz.idex_bubble = 1'b1;
               if (md_cnt != '0) begin
                  md_cnt_next = md_cnt - 1'b1;
               end else begin
                  state_next   = RUN;
                  md_done_next = 1'b1;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end
endmodule
